heart_rate_counter: RTL
=======================

Name: heart_rate_counter

Overview:
- Downstream of the peak finder: consumes its foundPeak indication and produces the displayed heart rate.
- Counts accepted peaks over a fixed measurement window and scales the count to beats per minute (BPM).
- Converts the BPM value to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- The digits feed the seven-segment multiplexer/decoder path.

Parameters:
- WINDOW_CYCLES, 400000000: clk cycles per measurement window (10 s at 40 MHz).
- BPM_MULT, 6: windows per minute; BPM = peaks * BPM_MULT.
- REFRACTORY_CYCLES, 12000000: lockout after an accepted peak (0.3 s); must be >= 1.
- Legality: WINDOW_CYCLES must be >= 16, so that a conversion always finishes before the next window ends.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- foundPeak  in  1  peak indication from the peak finder; sck domain, level may be held for many cycles.
- heartRate  out  10  latched BPM of the last completed window, 0..999.
- digit1  out  4  BCD ones digit.
- digit2  out  4  BCD tens digit.
- digit3  out  4  BCD hundreds digit.
- rateValid  out  1  one-cycle pulse when the digits update.
- peakSeen  out  1  one-cycle pulse per accepted peak (LED/debug).

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0.
  - Synchronizer, window counter, peak counter, refractory counter, shift register all cleared; FSM = IDLE.
  - Applies at any time, including mid-conversion; the in-flight result is discarded and no rateValid is issued.
  - After release, the window starts at count 0.
- Input path:
  - foundPeak passes through a 2-flop synchronizer, then rising-edge detection on the synchronized value.
  - A held-high level yields exactly one edge.
- Peak acceptance:
  - An edge is accepted only if the refractory counter is 0.
  - On acceptance: peakSeen=1 for that cycle; refractory loads REFRACTORY_CYCLES and decrements to 0.
  - Edges arriving while refractory > 0 are ignored.
  - Latency: a foundPeak rise is reported on peakSeen on the 3rd clk edge after it is sampled.
- Peak counter:
  - 8-bit, saturates at 255 (no wrap).
- Window counter:
  - Counts 0..WINDOW_CYCLES-1 and wraps.
  - The terminal cycle is T (count = WINDOW_CYCLES-1).
- At T:
  - heartRate <= min(peaks_incl_T * BPM_MULT, 999), where peaks_incl_T includes any peak accepted in cycle T.
  - The product is computed at 16 bits before clamping.
  - The peak counter is cleared to 0.
  - FSM enters CONV with a 10-bit value loaded into the double-dabble register.
  - heartRate is visible at T+1.
- Accepted peak exactly in cycle T: counted in the window ending at T, not the next one.
- FSM states:
  - IDLE: waits for T.
  - CONV: 10 cycles, one shift-add-3 iteration each; add 3 to any BCD nibble >= 5 before each shift.
  - DONE: one cycle; writes digit1/2/3 and pulses rateValid; then returns to IDLE.
- Conversion timing:
  - Digits and rateValid are visible at T+12.
  - Digits hold their value until the next DONE.
  - Digits and heartRate never show a partial conversion.
- A window with 0 peaks gives heartRate=0, digits 0,0,0, and rateValid is still pulsed.

Test Plan (WINDOW_CYCLES=100, REFRACTORY_CYCLES=5, BPM_MULT=6 unless stated):
1. Reset release, no foundPeak activity for 100 cycles -> all outputs 0 until T; rateValid pulses at T+12 with heartRate=0 and digits 0,0,0.
2. 12 foundPeak pulses (each 2 cycles high), 7 cycles apart, within one window -> 12 peakSeen pulses; heartRate=72 at T+1; digit3,2,1 = 0,7,2 with a single rateValid at T+12.
3. Refractory and held level:
   - two rising edges 3 cycles apart -> one peakSeen;
   - foundPeak held high for 50 cycles -> one peakSeen;
   - window of only these two events gives heartRate=12.
4. Saturation (WINDOW_CYCLES=2000, REFRACTORY_CYCLES=2, pulses every 4 cycles):
   - peak counter stops at 255;
   - heartRate=999, digits 9,9,9.
5. Boundary: peak accepted exactly in cycle T -> counted in the ending window (heartRate=6 if it is the only peak); next window with no peaks reports 0.
6. reset driven low during CONV (cycle T+5) for 1 cycle -> all outputs 0 immediately, no rateValid; the following full window with 3 peaks reports 18 (digits 0,1,8).

Source files
------------

// File: rtl/heart_rate_counter.sv
// Heart-rate counter: counts refractory-filtered peaks per window, scales to BPM,
// and converts the latched rate to three BCD digits with a sequential double-dabble.
module heart_rate_counter #(
  parameter int unsigned WINDOW_CYCLES     = 400000000,
  parameter int unsigned BPM_MULT          = 6,
  parameter int unsigned REFRACTORY_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       foundPeak,
  output logic [9:0] heartRate,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       rateValid,
  output logic       peakSeen
);

  localparam int unsigned WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned REF_W    = $clog2(REFRACTORY_CYCLES + 1);
  localparam int unsigned PEAK_W   = 8;
  localparam int unsigned RATE_W   = 10;
  localparam int unsigned PROD_W   = 16;
  localparam int unsigned BCD_W    = 12;
  localparam int unsigned DD_W     = BCD_W + RATE_W;
  localparam int unsigned ITER_W   = 4;
  localparam int unsigned DD_ITERS = RATE_W;
  localparam int unsigned RATE_MAX = 999;
  localparam int unsigned PEAK_MAX = 255;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  logic              sync1_q, sync2_q, prev_q;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [PEAK_W-1:0] peak_cnt_q, peak_cnt_d;
  logic [REF_W-1:0]  refr_q, refr_d;
  state_e            state_q, state_d;
  logic [DD_W-1:0]   dd_q, dd_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [RATE_W-1:0] heart_rate_q, heart_rate_d;
  logic [3:0]        digit1_q, digit1_d;
  logic [3:0]        digit2_q, digit2_d;
  logic [3:0]        digit3_q, digit3_d;
  logic              rate_valid_q, rate_valid_d;
  logic              peak_seen_q, peak_seen_d;

  logic              accept_c;
  logic              win_end_c;
  logic [PEAK_W-1:0] peaks_incl_c;
  logic [PROD_W-1:0] product_c;
  logic [RATE_W-1:0] rate_c;

  // One shift-add-3 iteration over the BCD field sitting above the binary field.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] t;
    logic [3:0]      nib;
    t = v;
    for (int i = 0; i < 3; i++) begin
      nib = t[RATE_W + 4*i +: 4];
      if (nib >= 4'd5) begin
        t[RATE_W + 4*i +: 4] = nib + 4'd3;
      end
    end
    return {t[DD_W-2:0], 1'b0};
  endfunction

  // Peak qualification and window bookkeeping.
  always_comb begin
    accept_c  = sync2_q && !prev_q && (refr_q == '0);
    win_end_c = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));

    peaks_incl_c = peak_cnt_q;
    if (accept_c && (peak_cnt_q != PEAK_W'(PEAK_MAX))) begin
      peaks_incl_c = peak_cnt_q + PEAK_W'(1);
    end

    product_c = PROD_W'(peaks_incl_c) * PROD_W'(BPM_MULT);
    rate_c    = (product_c > PROD_W'(RATE_MAX)) ? RATE_W'(RATE_MAX) : product_c[RATE_W-1:0];
  end

  always_comb begin
    win_cnt_d    = win_end_c ? '0 : win_cnt_q + WIN_W'(1);
    peak_cnt_d   = win_end_c ? '0 : peaks_incl_c;
    peak_seen_d  = accept_c;
    heart_rate_d = win_end_c ? rate_c : heart_rate_q;

    refr_d = refr_q;
    if (accept_c) begin
      refr_d = REF_W'(REFRACTORY_CYCLES);
    end else if (refr_q != '0) begin
      refr_d = refr_q - REF_W'(1);
    end
  end

  // Conversion FSM: IDLE waits for window end, CONV runs the dabble, DONE publishes.
  always_comb begin
    state_d      = state_q;
    dd_d         = dd_q;
    iter_d       = iter_q;
    digit1_d     = digit1_q;
    digit2_d     = digit2_q;
    digit3_d     = digit3_q;
    rate_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_end_c) begin
          dd_d    = {BCD_W'(0), rate_c};
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        dd_d   = dd_step(dd_q);
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(DD_ITERS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        digit3_d     = dd_q[DD_W-1 -: 4];
        digit2_d     = dd_q[DD_W-5 -: 4];
        digit1_d     = dd_q[DD_W-9 -: 4];
        rate_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      win_cnt_q    <= '0;
      peak_cnt_q   <= '0;
      refr_q       <= '0;
      state_q      <= IDLE;
      dd_q         <= '0;
      iter_q       <= '0;
      heart_rate_q <= '0;
      digit1_q     <= '0;
      digit2_q     <= '0;
      digit3_q     <= '0;
      rate_valid_q <= 1'b0;
      peak_seen_q  <= 1'b0;
    end else begin
      sync1_q      <= foundPeak;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      win_cnt_q    <= win_cnt_d;
      peak_cnt_q   <= peak_cnt_d;
      refr_q       <= refr_d;
      state_q      <= state_d;
      dd_q         <= dd_d;
      iter_q       <= iter_d;
      heart_rate_q <= heart_rate_d;
      digit1_q     <= digit1_d;
      digit2_q     <= digit2_d;
      digit3_q     <= digit3_d;
      rate_valid_q <= rate_valid_d;
      peak_seen_q  <= peak_seen_d;
    end
  end

  assign heartRate = heart_rate_q;
  assign digit1    = digit1_q;
  assign digit2    = digit2_q;
  assign digit3    = digit3_q;
  assign rateValid = rate_valid_q;
  assign peakSeen  = peak_seen_q;

endmodule
